// File: rtl/run_detector_pkg.sv
// rtl/run_detector_pkg.sv - shared state encoding and width helper for run_detector
package run_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONES  = 2'd1,
    ZEROS = 2'd2
  } state_t;

  // Width needed to hold a run count of 0..run_len.
  function automatic int run_len_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// rtl/run_detector_if.sv - sample stream in, hit/count status out
interface run_detector_if
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
);
  localparam int RLW = run_len_w(RUN_LEN);

  logic             in_valid;
  logic             in_bit;
  logic             overlap;
  logic             clear;
  logic             hit;
  logic             hit_value;
  logic [RLW-1:0]   run_len;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output in_valid, in_bit, overlap, clear,
    input  hit, hit_value, run_len, hit_count
  );

  modport slave (
    input  in_valid, in_bit, overlap, clear,
    output hit, hit_value, run_len, hit_count
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, clr has priority over inc
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - flags runs of RUN_LEN identical bits in a qualified serial stream
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic          clock,
  input  logic          reset,
  run_detector_if.slave bus
);

  localparam int             RLW  = run_len_w(RUN_LEN);
  localparam logic [RLW-1:0] ONE  = RLW'(1);
  localparam logic [RLW-1:0] LAST = RLW'(RUN_LEN - 1);
  localparam logic [RLW-1:0] FULL = RLW'(RUN_LEN);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [RLW-1:0] r_cnt;
  logic [RLW-1:0] w_cnt_nxt;
  logic [RLW-1:0] w_cnt_inc;
  logic           r_hit;
  logic           r_hit_value;
  logic           w_hit_nxt;
  logic           w_hit_value_nxt;
  logic           w_match;
  logic           w_complete;

  // IDLE never matches, so the first sample after IDLE takes the mismatch path.
  assign w_match    = ((r_state == ONES) && bus.in_bit) || ((r_state == ZEROS) && !bus.in_bit);
  assign w_cnt_inc  = r_cnt + ONE;
  assign w_complete = bus.in_valid && w_match && (w_cnt_inc == FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_hit_value <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hit       <= w_hit_nxt;
      r_hit_value <= w_hit_value_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (bus.in_valid) begin
      if (!w_match) begin
        w_state_nxt = bus.in_bit ? ONES : ZEROS;
        w_cnt_nxt   = ONE;
      end else if (w_complete) begin
        if (bus.overlap) begin
          w_cnt_nxt = LAST;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_hit_nxt       = !bus.clear && w_complete;
    w_hit_value_nxt = w_hit_nxt ? bus.in_bit : r_hit_value;
  end

  sat_counter #(.W(CNT_W)) u_hit_count (
    .clock (clock),
    .reset (reset),
    .inc   (w_hit_nxt),
    .clr   (bus.clear),
    .value (bus.hit_count)
  );

  assign bus.hit       = r_hit;
  assign bus.hit_value = r_hit_value;
  assign bus.run_len   = r_cnt;

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - directed self-checking bench for run_detector
module tb_run_detector;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  run_detector_if #(.RUN_LEN(2), .CNT_W(8)) if_a ();
  run_detector_if #(.RUN_LEN(4), .CNT_W(8)) if_b ();
  run_detector_if #(.RUN_LEN(3), .CNT_W(8)) if_c ();
  run_detector_if #(.RUN_LEN(2), .CNT_W(2)) if_d ();

  run_detector #(.RUN_LEN(2), .CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
  run_detector #(.RUN_LEN(4), .CNT_W(8)) dut_b (.clock(clock), .reset(reset), .bus(if_b));
  run_detector #(.RUN_LEN(3), .CNT_W(8)) dut_c (.clock(clock), .reset(reset), .bus(if_c));
  run_detector #(.RUN_LEN(2), .CNT_W(2)) dut_d (.clock(clock), .reset(reset), .bus(if_d));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle of stimulus on the selected instance; others see in_valid=0.
  task automatic cyc(input int sel, input logic v, input logic b, input logic ov, input logic clr);
    @(negedge clock);
    if_a.in_valid = 1'b0; if_a.clear = 1'b0;
    if_b.in_valid = 1'b0; if_b.clear = 1'b0;
    if_c.in_valid = 1'b0; if_c.clear = 1'b0;
    if_d.in_valid = 1'b0; if_d.clear = 1'b0;
    case (sel)
      0: begin if_a.in_valid = v; if_a.in_bit = b; if_a.overlap = ov; if_a.clear = clr; end
      1: begin if_b.in_valid = v; if_b.in_bit = b; if_b.overlap = ov; if_b.clear = clr; end
      2: begin if_c.in_valid = v; if_c.in_bit = b; if_c.overlap = ov; if_c.clear = clr; end
      default: begin if_d.in_valid = v; if_d.in_bit = b; if_d.overlap = ov; if_d.clear = clr; end
    endcase
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({if_a.hit, if_a.hit_value, if_a.run_len, if_a.hit_count} !== 12'h000) begin
      n_errors++; $display("FAIL reset_a actual=%h required=000", {if_a.hit, if_a.hit_value, if_a.run_len, if_a.hit_count});
    end
    n_checks++;
    if ({if_b.hit, if_b.hit_value, if_b.run_len, if_b.hit_count} !== 13'h0000) begin
      n_errors++; $display("FAIL reset_b actual=%h required=0000", {if_b.hit, if_b.hit_value, if_b.run_len, if_b.hit_count});
    end
    n_checks++;
    if ({if_d.hit, if_d.hit_value, if_d.run_len, if_d.hit_count} !== 6'h00) begin
      n_errors++; $display("FAIL reset_d actual=%h required=00", {if_d.hit, if_d.hit_value, if_d.run_len, if_d.hit_count});
    end
  endtask

  task automatic test_pair;
    logic [15:0] stream;
    logic [15:0] mask_no;
    logic [15:0] mask_ov;
    logic [15:0] hv_no;
    stream  = 16'b0101011101110010;
    mask_no = 16'h0228;   // hits after samples 3, 5, 9
    mask_ov = 16'h0668;   // hits after samples 3, 5, 6, 9, 10
    hv_no   = 16'hFE00;   // held hit_value: 0 up to sample 8, 1 from sample 9 on (sample 5 hit is 1)
    hv_no[5] = 1'b1; hv_no[6] = 1'b1; hv_no[7] = 1'b1; hv_no[8] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1'b1, stream[i], 1'b0, 1'b0);
      n_checks++;
      if (if_a.hit !== mask_no[i]) begin
        n_errors++; $display("FAIL pair_hit[%0d] actual=%b required=%b", i, if_a.hit, mask_no[i]);
      end
      n_checks++;
      if (if_a.hit_value !== hv_no[i]) begin
        n_errors++; $display("FAIL pair_hit_value[%0d] actual=%b required=%b", i, if_a.hit_value, hv_no[i]);
      end
    end
    n_checks++;
    if (if_a.hit_count !== 8'd3) begin
      n_errors++; $display("FAIL pair_count actual=%0d required=3", if_a.hit_count);
    end
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (if_a.hit_count !== 8'd0) begin
      n_errors++; $display("FAIL pair_clear_count actual=%0d required=0", if_a.hit_count);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1'b1, stream[i], 1'b1, 1'b0);
      n_checks++;
      if (if_a.hit !== mask_ov[i]) begin
        n_errors++; $display("FAIL pair_ov_hit[%0d] actual=%b required=%b", i, if_a.hit, mask_ov[i]);
      end
    end
    n_checks++;
    if (if_a.hit_count !== 8'd5) begin
      n_errors++; $display("FAIL pair_ov_count actual=%0d required=5", if_a.hit_count);
    end
  endtask

  task automatic test_run4;
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (if_b.hit !== (i == 3)) begin
        n_errors++; $display("FAIL run4_hit[%0d] actual=%b required=%b", i, if_b.hit, (i == 3));
      end
    end
    n_checks++;
    if (if_b.run_len !== 3'd3) begin
      n_errors++; $display("FAIL run4_run_len actual=%0d required=3", if_b.run_len);
    end
    n_checks++;
    if (if_b.hit_count !== 8'd1) begin
      n_errors++; $display("FAIL run4_count actual=%0d required=1", if_b.hit_count);
    end
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (if_b.hit !== (i >= 3)) begin
        n_errors++; $display("FAIL run4_ov_hit[%0d] actual=%b required=%b", i, if_b.hit, (i >= 3));
      end
    end
    n_checks++;
    if (if_b.hit_count !== 8'd4) begin
      n_errors++; $display("FAIL run4_ov_count actual=%0d required=4", if_b.hit_count);
    end
  endtask

  task automatic test_gaps;
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(2, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({if_c.hit, if_c.run_len} !== 3'b001) begin
        n_errors++; $display("FAIL gap1_idle[%0d] actual=%b required=001", i, {if_c.hit, if_c.run_len});
      end
    end
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({if_c.hit, if_c.run_len} !== 3'b010) begin
      n_errors++; $display("FAIL gap2_idle actual=%b required=010", {if_c.hit, if_c.run_len});
    end
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({if_c.hit, if_c.hit_value, if_c.run_len, if_c.hit_count} !== {1'b1, 1'b0, 2'd0, 8'd1}) begin
      n_errors++; $display("FAIL gap_hit actual=%h required=%h", {if_c.hit, if_c.hit_value, if_c.run_len, if_c.hit_count}, {1'b1, 1'b0, 2'd0, 8'd1});
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt;
    for (int i = 0; i < 9; i++) begin
      cyc(3, 1'b1, 1'b1, 1'b1, 1'b0);
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      n_checks++;
      if (if_d.hit_count !== exp_cnt) begin
        n_errors++; $display("FAIL sat_count[%0d] actual=%0d required=%0d", i, if_d.hit_count, exp_cnt);
      end
    end
    cyc(3, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({if_d.hit, if_d.hit_value, if_d.run_len, if_d.hit_count} !== 6'b010000) begin
      n_errors++; $display("FAIL sat_clear actual=%b required=010000", {if_d.hit, if_d.hit_value, if_d.run_len, if_d.hit_count});
    end
    n_checks++;
    if (dut_d.r_state !== run_detector_pkg::IDLE) begin
      n_errors++; $display("FAIL sat_clear_state actual=%0d required=0", dut_d.r_state);
    end
  endtask

  task automatic test_reset_mid_run;
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({if_b.run_len, if_b.hit_count} !== {3'd3, 8'd1}) begin
      n_errors++; $display("FAIL mid_pre actual=%h required=%h", {if_b.run_len, if_b.hit_count}, {3'd3, 8'd1});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({if_b.hit, if_b.run_len, if_b.hit_count} !== 12'h000) begin
      n_errors++; $display("FAIL mid_async actual=%h required=000", {if_b.hit, if_b.run_len, if_b.hit_count});
    end
    #1 reset = 1'b0;
    cyc(1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({if_b.hit, if_b.run_len} !== 4'b0001) begin
      n_errors++; $display("FAIL mid_restart actual=%b required=0001", {if_b.hit, if_b.run_len});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_bit = 1'b0; if_a.overlap = 1'b0; if_a.clear = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_bit = 1'b0; if_b.overlap = 1'b0; if_b.clear = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_bit = 1'b0; if_c.overlap = 1'b0; if_c.clear = 1'b0;
    if_d.in_valid = 1'b0; if_d.in_bit = 1'b0; if_d.overlap = 1'b0; if_d.clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_pair();
    test_run4();
    test_gaps();
    test_saturation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
